w_pkt_writer: RTL

Write-side frame packetizer feeding the FIFO write controller (`w_ctrl`) in the `w_clk` domain. It accepts a word stream with end-of-frame marking over a valid/ready handshake and buffers it in a 2-entry skid buffer. Each frame is written into the FIFO as header word + payload words + checksum word, with the write strobe gated by the controller's `w_full`. The read side can therefore delimit and verify frames without extra sideband.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/w_pkt_writer_if.sv | 36 +++
 rtl/skid_buf2.sv | 52 +++++
 rtl/w_pkt_writer.sv | 119 +++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the write-side FIFO packetizer.
//   state_t     : packetizer FSM state (2-bit encoding)
//   HDR_TAG_DEF : default constant placed in the top byte of a header word
//   SEQ_W       : width of the per-frame sequence number
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_SUM  = 2'd3
  } state_t;

  localparam logic [7:0] HDR_TAG_DEF = 8'hA5;
  localparam int         SEQ_W       = 8;

endpackage

// File: rtl/w_pkt_writer_if.sv
// Bus bundle between the producer / w_ctrl side and w_pkt_writer.
//
// Handshake: a word {s_last, s_data} transfers on a rising w_clk edge where
// s_valid and s_ready are both 1. s_ready depends only on registered state,
// never on s_valid or w_full. A producer holding s_valid must keep s_data and
// s_last stable until the transfer. w_en is a write strobe, not a handshake:
// it is never high while w_full is high, so every w_en cycle is a real write.
//
//   s_data/s_valid/s_last : producer word stream into the packetizer
//   s_ready               : packetizer can accept a word this cycle
//   w_full                : full flag from w_ctrl
//   w_en/w_data           : FIFO write strobe and word to w_ctrl
//
// The master modport is the environment (producer plus w_ctrl); the slave
// modport is the packetizer.
interface w_pkt_writer_if #(
  parameter int DW = 16
);
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          w_full;
  logic          w_en;
  logic [DW-1:0] w_data;

  modport master (
    output s_data, s_valid, s_last, w_full,
    input  s_ready, w_en, w_data
  );

  modport slave (
    input  s_data, s_valid, s_last, w_full,
    output s_ready, w_en, w_data
  );
endinterface

// File: rtl/skid_buf2.sv
// Two-entry in-order buffer.
//   clk, rst   : clock and synchronous active-high reset
//   push/pdata : write a word (ignored when full)
//   pop        : drop the head word (ignored when empty)
//   head       : oldest stored word
//   count      : number of stored words, 0..2
// Push and pop in the same cycle leave count unchanged.
module skid_buf2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] pdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (count_q != 2'd2);
  assign do_pop  = pop  && (count_q != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= pdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/w_pkt_writer.sv
// Write-side frame packetizer. Buffers the producer stream in a 2-entry skid
// buffer and writes each frame to the FIFO as header + payload + checksum.
//   w_clk, rst : write clock, synchronous active-high reset
//   bus        : producer stream, w_full in, w_en/w_data out
//   seq        : sequence number of the current/next frame
//   busy       : FSM not idle or buffer holds words
//   dbg_state  : current FSM state
module w_pkt_writer
  import fifo_pkg::*;
#(
  parameter int         DW      = 16,
  parameter logic [7:0] HDR_TAG = HDR_TAG_DEF
) (
  input  logic             w_clk,
  input  logic             rst,
  w_pkt_writer_if.slave    bus,
  output logic [SEQ_W-1:0] seq,
  output logic             busy,
  output state_t           dbg_state
);

  state_t           state_q, state_d;
  logic [DW-1:0]    sum_q, sum_d;
  logic [SEQ_W-1:0] seq_q, seq_d;

  logic [DW:0]      head;
  logic [DW-1:0]    head_data;
  logic             head_last;
  logic [1:0]       count;
  logic             push;
  logic             pop;
  logic             w_en;
  logic [DW-1:0]    w_data;
  logic [DW-1:0]    hdr_word;

  // s_ready comes only from the registered count.
  assign bus.s_ready = (count != 2'd2);
  assign push        = bus.s_valid && bus.s_ready;
  assign head_data   = head[DW-1:0];
  assign head_last   = head[DW];

  skid_buf2 #(.W(DW + 1)) u_buf (
    .clk   (w_clk),
    .rst   (rst),
    .push  (push),
    .pdata ({bus.s_last, bus.s_data}),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

  // Tag in the top byte, sequence number in the low byte, zeros between.
  always_comb begin
    hdr_word                = '0;
    hdr_word[SEQ_W-1:0]     = seq_q;
    hdr_word[DW-1 -: 8]     = HDR_TAG;
  end

  always_ff @(posedge w_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      seq_q   <= seq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    seq_d   = seq_q;
    w_en    = 1'b0;
    w_data  = '0;
    pop     = 1'b0;
    case (state_q)
      // Leaving on an incoming push lets the header go out the cycle after
      // the first word is accepted.
      ST_IDLE: begin
        if ((count != 2'd0) || push) state_d = ST_HDR;
      end
      ST_HDR: begin
        w_en   = ~bus.w_full;
        w_data = hdr_word;
        if (w_en) begin
          sum_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        w_en   = (count != 2'd0) && !bus.w_full;
        w_data = head_data;
        if (w_en) begin
          pop   = 1'b1;
          sum_d = sum_q + head_data;   // carry discarded
          if (head_last) state_d = ST_SUM;
        end
      end
      ST_SUM: begin
        w_en   = ~bus.w_full;
        w_data = sum_q;
        if (w_en) begin
          seq_d   = seq_q + 1'b1;      // 255 wraps to 0
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.w_en   = w_en;
  assign bus.w_data = w_data;
  assign seq        = seq_q;
  assign busy       = (state_q != ST_IDLE) || (count != 2'd0);
  assign dbg_state  = state_q;

endmodule
